// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: state enum, opcodes,
// datapath mux selects and the Moore control word produced by fsm_outdec.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRLINK = 4'd12,
    TRAP     = 4'd13
  } statetype_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // State-only part of the control word; the top adds the mem_ready/BranchC terms.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic       done;
    logic       illegal;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  function automatic logic is_known_op(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_JALR: is_known_op = 1'b1;
      default:                                         is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_fsm_if.sv
// Shared instruction/data memory request handshake between the control FSM
// (master) and the memory port (slave).
interface multicycle_fsm_if;
  logic mem_req;
  logic MemWrite;
  logic AdrSrc;
  logic mem_ready;

  modport master (output mem_req, output MemWrite, output AdrSrc, input mem_ready);
  modport slave  (input mem_req, input MemWrite, input AdrSrc, output mem_ready);
endinterface

// File: rtl/fsm_outdec.sv
// Pure state-to-control-word decode for the multicycle FSM. The illegal flag in
// TRAP is only produced when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
module fsm_outdec
  import mc_pkg::*;
(
  input  statetype_t state,
  output ctrl_t      ctrl
);

  // Moore control word per state; everything not set stays 0 / select 00.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.result_src = RES_READDATA;
        ctrl.reg_write  = 1'b1;
        ctrl.done       = 1'b1;
      end
      MEMWRITE: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.done       = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_BRANCH;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.done       = 1'b1;
      end
      JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      JALR: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_update  = 1'b1;
      end
      JALRLINK: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.reg_write  = 1'b1;
        ctrl.done       = 1'b1;
      end
      TRAP: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ctrl.illegal = 1'b1;
`else
        ctrl = '0;
`endif
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_fsm.sv
// Main control FSM of the multicycle RV32I datapath: state register, next-state
// logic and PCWrite/IRWrite/instr_done gating. Optional: MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_fsm
  import mc_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             op,
  input  logic                   BranchC,
  multicycle_fsm_if.master       mem,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   RegWrite,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             ResultSrc,
  output logic                   instr_done,
  output logic                   illegal
);

  statetype_t state_r;
  statetype_t state_next_s;
  ctrl_t      ctrl_s;
  logic       nop_s;

  fsm_outdec u_outdec (
    .state (state_r),
    .ctrl  (ctrl_s)
  );

  // Unknown opcodes either retire as a NOP in DECODE or divert to TRAP.
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign nop_s = 1'b0;
`else
  assign nop_s = (state_r == DECODE) && !is_known_op(op);
`endif

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; memory states hold until mem_ready.
  always_comb begin
    state_next_s = FETCH;
    case (state_r)
      FETCH:    state_next_s = mem.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_R:         state_next_s = EXECUTER;
          OP_I:         state_next_s = EXECUTEI;
          OP_B:         state_next_s = BRANCH;
          OP_JAL:       state_next_s = JAL;
          OP_JALR:      state_next_s = JALR;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      state_next_s = TRAP;
`else
          default:      state_next_s = FETCH;
`endif
        endcase
      end
      MEMADR:   state_next_s = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next_s = mem.mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_next_s = FETCH;
      MEMWRITE: state_next_s = mem.mem_ready ? FETCH : MEMWRITE;
      EXECUTER: state_next_s = ALUWB;
      EXECUTEI: state_next_s = ALUWB;
      ALUWB:    state_next_s = FETCH;
      BRANCH:   state_next_s = FETCH;
      JAL:      state_next_s = ALUWB;
      JALR:     state_next_s = JALRLINK;
      JALRLINK: state_next_s = FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      TRAP:     state_next_s = TRAP;
`else
      TRAP:     state_next_s = FETCH;
`endif
      default:  state_next_s = FETCH;
    endcase
  end

  // Output gating: writes and requests are suppressed while reset aborts the instruction.
  always_comb begin
    mem.AdrSrc   = ctrl_s.adr_src;
    ALUSrcA      = ctrl_s.alu_src_a;
    ALUSrcB      = ctrl_s.alu_src_b;
    ALUOp        = ctrl_s.alu_op;
    ResultSrc    = ctrl_s.result_src;
    illegal      = ctrl_s.illegal;
    mem.mem_req  = 1'b0;
    mem.MemWrite = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    instr_done   = 1'b0;
    if (reset) begin
      mem.mem_req = 1'b0;
    end else begin
      mem.mem_req  = ctrl_s.mem_req;
      mem.MemWrite = ctrl_s.mem_write;
      RegWrite     = ctrl_s.reg_write;
      IRWrite      = (state_r == FETCH) && mem.mem_ready;
      PCWrite      = ctrl_s.pc_update
                   | ((state_r == FETCH) && mem.mem_ready)
                   | (ctrl_s.branch && BranchC);
      instr_done   = ctrl_s.done
                   | ((state_r == MEMWRITE) && mem.mem_ready)
                   | nop_s;
    end
  end

endmodule
